// File: rtl/multicycle_ctrl.sv
// Multicycle CPU control FSM: FETCH/DECODE/EXEC/MEM/WB sequencing, datapath control, retire counter.
// Latency: ALU/jal/jalr 4 cycles, branch 3, store 4, load 5 (mem_ready=1); outputs are combinational from state/op_q.
// Backpressure: mem_ready=0 stalls in FETCH and MEM with outputs held; mem_ready is ignored in other states.
module multicycle_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  op,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        wmem,
    output logic        memc,
    output logic        m2reg,
    output logic        wreg,
    output logic        jal,
    output logic [2:0]  ALUOp,
    output logic        alucsrc,
    output logic [1:0]  PCsrc,
    output logic        pc_we,
    output logic        ir_we,
    output logic [2:0]  state,
    output logic [15:0] instret
);

    // CPU opcode encoding of the instruction register op field
    localparam logic [3:0] OP_JAL  = 4'b0000;
    localparam logic [3:0] OP_JALR = 4'b0001;
    localparam logic [3:0] OP_BEQ  = 4'b0010;
    localparam logic [3:0] OP_BLE  = 4'b0011;
    localparam logic [3:0] OP_LB   = 4'b0100;
    localparam logic [3:0] OP_LW   = 4'b0101;
    localparam logic [3:0] OP_SB   = 4'b0110;
    localparam logic [3:0] OP_SW   = 4'b0111;
    localparam logic [3:0] OP_ADD  = 4'b1000;
    localparam logic [3:0] OP_SUB  = 4'b1001;
    localparam logic [3:0] OP_AND  = 4'b1010;
    localparam logic [3:0] OP_OR   = 4'b1011;
    localparam logic [3:0] OP_ADDI = 4'b1100;
    localparam logic [3:0] OP_SUBI = 4'b1101;
    localparam logic [3:0] OP_ANDI = 4'b1110;
    localparam logic [3:0] OP_ORI  = 4'b1111;

    // ALU operation codes
    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_OR  = 3'd3;
    localparam logic [2:0] ALU_BEQ = 3'd4;
    localparam logic [2:0] ALU_BLE = 3'd5;

    // PC source select
    localparam logic [1:0] PC_SEQ = 2'd0;  // PC+2
    localparam logic [1:0] PC_REL = 2'd1;  // PC+imm
    localparam logic [1:0] PC_REG = 2'd2;  // rs1+imm

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [3:0]  op_q;
    logic [15:0] instret_q;

    // Raw (ungated) control values from the FSM decode
    logic        mem_req_c;
    logic        wmem_c;
    logic        memc_c;
    logic        m2reg_c;
    logic        wreg_c;
    logic        jal_c;
    logic [2:0]  aluop_c;
    logic        alucsrc_c;
    logic [1:0]  pcsrc_c;
    logic        pc_we_c;
    logic        ir_we_c;

    // Opcode class flags, all derived from the latched opcode only
    logic        is_load;
    logic        is_store;
    logic        is_branch;
    logic        is_link;
    logic [2:0]  dec_aluop;
    logic        dec_alucsrc;

    // ALU control for the latched opcode; shared by EXEC and WB so WB holds the EXEC values
    always_comb begin
        dec_aluop   = ALU_ADD;
        dec_alucsrc = 1'b0;
        case (op_q)
            OP_ADD:  begin dec_aluop = ALU_ADD; dec_alucsrc = 1'b0; end
            OP_SUB:  begin dec_aluop = ALU_SUB; dec_alucsrc = 1'b0; end
            OP_AND:  begin dec_aluop = ALU_AND; dec_alucsrc = 1'b0; end
            OP_OR:   begin dec_aluop = ALU_OR;  dec_alucsrc = 1'b0; end
            OP_ADDI: begin dec_aluop = ALU_ADD; dec_alucsrc = 1'b1; end
            OP_SUBI: begin dec_aluop = ALU_SUB; dec_alucsrc = 1'b1; end
            OP_ANDI: begin dec_aluop = ALU_AND; dec_alucsrc = 1'b1; end
            OP_ORI:  begin dec_aluop = ALU_OR;  dec_alucsrc = 1'b1; end
            OP_LB, OP_LW, OP_SB, OP_SW:
                     begin dec_aluop = ALU_ADD; dec_alucsrc = 1'b1; end
            OP_BEQ:  begin dec_aluop = ALU_BEQ; dec_alucsrc = 1'b0; end
            OP_BLE:  begin dec_aluop = ALU_BLE; dec_alucsrc = 1'b0; end
            OP_JAL:  begin dec_aluop = ALU_ADD; dec_alucsrc = 1'b0; end
            OP_JALR: begin dec_aluop = ALU_ADD; dec_alucsrc = 1'b1; end
            default: begin dec_aluop = ALU_ADD; dec_alucsrc = 1'b0; end
        endcase
    end

    assign is_load   = (op_q == OP_LB) || (op_q == OP_LW);
    assign is_store  = (op_q == OP_SB) || (op_q == OP_SW);
    assign is_branch = (op_q == OP_BEQ) || (op_q == OP_BLE);
    assign is_link   = (op_q == OP_JAL) || (op_q == OP_JALR);

    // State register; reset aborts any in-flight instruction and restarts at FETCH
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Opcode latch: captured once in DECODE so later states never see IR changes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q <= 4'd0;
        end else if (state_q == S_DECODE) begin
            op_q <= op;
        end
    end

    // Next-state and control decode; everything defaults to 0 so unlisted outputs stay low
    always_comb begin
        state_d   = S_FETCH;
        mem_req_c = 1'b0;
        wmem_c    = 1'b0;
        memc_c    = 1'b0;
        m2reg_c   = 1'b0;
        wreg_c    = 1'b0;
        jal_c     = 1'b0;
        aluop_c   = ALU_ADD;
        alucsrc_c = 1'b0;
        pcsrc_c   = PC_SEQ;
        pc_we_c   = 1'b0;
        ir_we_c   = 1'b0;
        case (state_q)
            S_FETCH: begin
                // Instruction fetch is a halfword read
                mem_req_c = 1'b1;
                wmem_c    = 1'b0;
                memc_c    = 1'b1;
                if (mem_ready) begin
                    ir_we_c = 1'b1;
                    state_d = S_DECODE;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_DECODE: begin
                state_d = S_EXEC;
            end
            S_EXEC: begin
                aluop_c   = dec_aluop;
                alucsrc_c = dec_alucsrc;
                if (is_branch) begin
                    // zero is only meaningful here, during the compare
                    pc_we_c = 1'b1;
                    pcsrc_c = zero ? PC_SEQ : PC_REL;
                    state_d = S_FETCH;
                end else if (is_load || is_store) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                // Address stays on the ALU (base+imm) for the whole access
                mem_req_c = 1'b1;
                aluop_c   = ALU_ADD;
                alucsrc_c = 1'b1;
                wmem_c    = is_store;
                memc_c    = (op_q == OP_LW) || (op_q == OP_SW);
                if (!mem_ready) begin
                    state_d = S_MEM;
                end else if (is_store) begin
                    pc_we_c = 1'b1;
                    pcsrc_c = PC_SEQ;
                    state_d = S_FETCH;
                end else begin
                    state_d = S_WB;
                end
            end
            S_WB: begin
                aluop_c   = dec_aluop;
                alucsrc_c = dec_alucsrc;
                wreg_c    = 1'b1;
                pc_we_c   = 1'b1;
                m2reg_c   = is_load;
                jal_c     = is_link;
                if (op_q == OP_JAL) begin
                    pcsrc_c = PC_REL;
                end else if (op_q == OP_JALR) begin
                    pcsrc_c = PC_REG;
                end else begin
                    pcsrc_c = PC_SEQ;
                end
                state_d = S_FETCH;
            end
            default: begin
                // Unused encodings recover to FETCH with every output low
                state_d = S_FETCH;
            end
        endcase
    end

    // Reset masks every control output combinationally, not just on the next edge
    assign mem_req = mem_req_c & ~rst;
    assign wmem    = wmem_c    & ~rst;
    assign memc    = memc_c    & ~rst;
    assign m2reg   = m2reg_c   & ~rst;
    assign wreg    = wreg_c    & ~rst;
    assign jal     = jal_c     & ~rst;
    assign ALUOp   = aluop_c   & {3{~rst}};
    assign alucsrc = alucsrc_c & ~rst;
    assign PCsrc   = pcsrc_c   & {2{~rst}};
    assign pc_we   = pc_we_c   & ~rst;
    assign ir_we   = ir_we_c   & ~rst;
    assign state   = state_q   & {3{~rst}};
    assign instret = instret_q & {16{~rst}};

    // Retire counter: one count per PC load, wrapping naturally at 16 bits
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instret_q <= 16'd0;
        end else begin
            instret_q <= instret_q + {15'd0, pc_we};
        end
    end

endmodule
